register_counter: RTL

Parametrised bus-attached register with slice-wise bus load and readback, up/down counting, and a wrap flag. Serves as program counter, stack pointer and memory-address register on the CPU's narrow data bus. The full-width value drives the address side continuously. The data bus side reads and writes one BUS_WIDTH slice at a time. Control inputs are active-low, matching the other bus registers.

---
 rtl/cpu_bus_pkg.sv | 18 +
 rtl/register_counter.sv | 103 ++++++++++
 2 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU's bus-attached registers: the per-cycle operation
// encoding and the slice-select width helper used by every multi-slice register.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } reg_op_t;

    // A single-slice register still carries a 1-bit select so that the
    // out-of-range code (1) reads back as a pulled-up bus.
    function automatic int sel_width(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/register_counter.sv
// Bus-attached up/down counter register (PC / SP / MAR): full value on the address side,
// slice-wise load and readback on the narrow data bus, one-cycle wrap flag.
module register_counter
    import cpu_bus_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               BUS_WIDTH   = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               NUM_SLICES  = WIDTH / BUS_WIDTH,
    parameter int               SEL_WIDTH   = sel_width(NUM_SLICES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] bus_in,
    input  logic [SEL_WIDTH-1:0] slice_sel,
    input  logic                 load_bus,
    input  logic                 assert_bus,
    input  logic                 count_up,
    input  logic                 count_down,
    output logic [BUS_WIDTH-1:0] bus_out,
    output logic                 bus_en,
    output logic [WIDTH-1:0]     value_out,
    output logic                 zero,
    output logic                 wrap
);

    if (WIDTH % BUS_WIDTH != 0) begin : g_bad_width
        $error("register_counter: WIDTH (%0d) must be a multiple of BUS_WIDTH (%0d)",
               WIDTH, BUS_WIDTH);
    end
    if (NUM_SLICES != WIDTH / BUS_WIDTH) begin : g_bad_slices
        $error("register_counter: NUM_SLICES is derived and must not be overridden");
    end

    // Power-on value matches the reset value so the register is defined before the first reset.
    logic [WIDTH-1:0]     value_q = RESET_VALUE;
    logic                 wrap_q  = 1'b0;

    logic [BUS_WIDTH-1:0] slice_val [NUM_SLICES];
    logic [NUM_SLICES-1:0] slice_hit;
    logic [WIDTH-1:0]     load_val;
    reg_op_t              op;

    // slice_hit is one-hot for an in-range select and all-zero otherwise, so an
    // out-of-range load rewrites the current value and the readback falls to all ones.
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        assign slice_val[s] = value_q[s*BUS_WIDTH +: BUS_WIDTH];
        assign slice_hit[s] = (slice_sel == SEL_WIDTH'(s));
        assign load_val[s*BUS_WIDTH +: BUS_WIDTH] = slice_hit[s] ? bus_in : slice_val[s];
    end

    always_comb begin
        bus_out = '1;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (slice_hit[i]) begin
                bus_out = slice_val[i];
            end
        end
    end

    // A load with an invalid select still wins over counting, it just writes nothing.
    always_comb begin
        op = OP_HOLD;
        if (!load_bus) begin
            op = OP_LOAD;
        end else if (!count_up && count_down) begin
            op = OP_INC;
        end else if (!count_down && count_up) begin
            op = OP_DEC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            unique case (op)
                OP_LOAD: begin
                    value_q <= load_val;
                    wrap_q  <= 1'b0;
                end
                OP_INC: begin
                    value_q <= value_q + WIDTH'(1);
                    wrap_q  <= &value_q;
                end
                OP_DEC: begin
                    value_q <= value_q - WIDTH'(1);
                    wrap_q  <= ~|value_q;
                end
                default: begin
                    wrap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign value_out = value_q;
    assign zero      = ~|value_q;
    assign wrap      = wrap_q;
    assign bus_en    = ~assert_bus;

endmodule
